// File: rtl/exe_stage.sv
// LoongArch execute stage: ALU/multiply, data-SRAM request generation, forwarding info.
// Define EXE_DIV_EN to build the 32-cycle restoring divider; otherwise div results read as 0.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [146:0] ds_to_es_data,
    output logic         es_to_ms_valid,
    output logic [75:0]  es_to_ms_data,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [38:0]  es_fwd_blk_data,
    input  logic         ms_ex_valid,
    input  logic         wb_ex,
    input  logic         wb_ertn_flush
);
    typedef struct packed {
        logic [3:0]  alu_op;
        logic        is_div;
        logic [1:0]  div_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd;
        logic        mem_we;
        logic        res_from_mem;
        logic [1:0]  mem_size;
        logic        mem_sext;
        logic        ex_in;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
    } ds_pkt_t;

    ds_pkt_t     es_q;
    logic        es_valid_q, es_valid_d;
    logic        flush, es_ready_go, mem_op, ex_ale, blk;
    logic [31:0] sum, alu_res, div_res, result, lane_wdata;
    logic [63:0] mul_u, mul_s;
    logic [3:0]  lane_we;
    logic        unused_ok;

    assign flush      = wb_ex | wb_ertn_flush;
    assign es_allowin = !es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go & !flush;

    always_comb begin
        es_valid_d = es_valid_q;
        if (flush)           es_valid_d = 1'b0;
        else if (es_allowin) es_valid_d = ds_to_es_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            es_q       <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            if (es_allowin && ds_to_es_valid) es_q <= ds_to_es_data;
        end
    end

    // Both products share one full-width multiply each; low half is identical for signed/unsigned.
    assign sum   = es_q.src1 + es_q.src2;
    assign mul_u = {32'd0, es_q.src1} * {32'd0, es_q.src2};
    assign mul_s = {{32{es_q.src1[31]}}, es_q.src1} * {{32{es_q.src2[31]}}, es_q.src2};

    always_comb begin
        alu_res = 32'd0;
        case (es_q.alu_op)
            4'd0:    alu_res = sum;
            4'd1:    alu_res = es_q.src1 - es_q.src2;
            4'd2:    alu_res = {31'd0, $signed(es_q.src1) < $signed(es_q.src2)};
            4'd3:    alu_res = {31'd0, es_q.src1 < es_q.src2};
            4'd4:    alu_res = es_q.src1 & es_q.src2;
            4'd5:    alu_res = es_q.src1 | es_q.src2;
            4'd6:    alu_res = ~(es_q.src1 | es_q.src2);
            4'd7:    alu_res = es_q.src1 ^ es_q.src2;
            4'd8:    alu_res = es_q.src1 << es_q.src2[4:0];
            4'd9:    alu_res = es_q.src1 >> es_q.src2[4:0];
            4'd10:   alu_res = $signed(es_q.src1) >>> es_q.src2[4:0];
            4'd11:   alu_res = es_q.src2;
            4'd12:   alu_res = mul_s[31:0];
            4'd13:   alu_res = mul_s[63:32];
            4'd14:   alu_res = mul_u[63:32];
            default: alu_res = 32'd0;
        endcase
    end

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    div_state_t  st_q, st_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, q_fix, r_fix;
    logic        s1_q, s1_d, s2_q, s2_d, a_neg, b_neg;
    logic [32:0] trial;

    assign a_neg = !es_q.div_op[1] & es_q.src1[31];
    assign b_neg = !es_q.div_op[1] & es_q.src2[31];
    // Dividend shifts out of the quotient register MSB-first into the partial remainder.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        case (st_q)
            IDLE: if (es_valid_q && es_q.is_div) begin
                st_d  = RUN;
                cnt_d = 5'd0;
                quo_d = a_neg ? 32'd0 - es_q.src1 : es_q.src1;
                dvs_d = b_neg ? 32'd0 - es_q.src2 : es_q.src2;
                rem_d = 32'd0;
                s1_d  = a_neg;
                s2_d  = b_neg;
            end
            RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[30:0], quo_q[31]};
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) st_d = DONE;
            end
            DONE: if (es_to_ms_valid && ms_allowin) st_d = IDLE;
            default: st_d = IDLE;
        endcase
        if (flush) st_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= IDLE;
            cnt_q <= 5'd0;
            quo_q <= 32'd0;
            rem_q <= 32'd0;
            dvs_q <= 32'd0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            s1_q  <= s1_d;
            s2_q  <= s2_d;
        end
    end

    assign q_fix = (s1_q ^ s2_q) ? 32'd0 - quo_q : quo_q;
    assign r_fix = s1_q ? 32'd0 - rem_q : rem_q;

    always_comb begin
        if (dvs_q == 32'd0) div_res = es_q.div_op[0] ? es_q.src1 : 32'd0;
        else                div_res = es_q.div_op[0] ? r_fix : q_fix;
    end

    assign es_ready_go = !es_q.is_div | (st_q == DONE);
    assign blk         = es_valid_q & (es_q.res_from_mem | (es_q.is_div & (st_q != DONE)));
    assign unused_ok   = ^mul_u[31:0];
`else
    assign div_res     = 32'd0;
    assign es_ready_go = 1'b1;
    assign blk         = es_valid_q & es_q.res_from_mem;
    assign unused_ok   = ^{mul_u[31:0], es_q.div_op};
`endif

    assign result = es_q.is_div ? div_res : alu_res;

    assign mem_op = es_q.mem_we | es_q.res_from_mem;
    assign ex_ale = es_valid_q & mem_op &
                    (((es_q.mem_size == 2'b01) & sum[0]) |
                     ((es_q.mem_size == 2'b10) & (sum[1:0] != 2'b00)));

    always_comb begin
        lane_we    = 4'b1111;
        lane_wdata = es_q.rkd;
        case (es_q.mem_size)
            2'b00: begin
                lane_we    = 4'b0001 << sum[1:0];
                lane_wdata = {4{es_q.rkd[7:0]}};
            end
            2'b01: begin
                lane_we    = sum[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{es_q.rkd[15:0]}};
            end
            default: ;
        endcase
    end

    assign data_sram_en    = es_valid_q & mem_op & !ex_ale & !es_q.ex_in & !ms_ex_valid &
                             !flush & ms_allowin;
    assign data_sram_we    = es_q.mem_we ? lane_we : 4'b0000;
    assign data_sram_addr  = sum;
    assign data_sram_wdata = lane_wdata;

    assign es_to_ms_data   = {es_q.ex_in, ex_ale, es_q.mem_sext, es_q.mem_size, es_q.res_from_mem,
                              es_q.gr_we, es_q.dest, result, es_q.pc};
    assign es_fwd_blk_data = {blk, es_valid_q & es_q.gr_we, es_q.dest, result};
endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; divider scenarios build only with EXE_DIV_EN.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset, ms_allowin, ds_to_es_valid, ms_ex_valid, wb_ex, wb_ertn_flush;
    logic [146:0] ds_to_es_data;
    logic         es_allowin, es_to_ms_valid, data_sram_en;
    logic [75:0]  es_to_ms_data;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic [38:0]  es_fwd_blk_data;
    int checks = 0;
    int errors = 0;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_data(ds_to_es_data),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_data(es_to_ms_data),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .es_fwd_blk_data(es_fwd_blk_data), .ms_ex_valid(ms_ex_valid),
        .wb_ex(wb_ex), .wb_ertn_flush(wb_ertn_flush)
    );

    always #5 clk = ~clk;

    wire [31:0] res = es_to_ms_data[63:32];
    wire        ale = es_to_ms_data[74];
    wire        blk = es_fwd_blk_data[38];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } alu_vec_t;

    function automatic logic [146:0] pkt(input logic [3:0] op, input logic dv, input logic [1:0] dop,
                                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                                         input logic we, input logic rfm, input logic [1:0] sz,
                                         input logic exin);
        return {op, dv, dop, a, b, r, we, rfm, sz, 1'b0, exin, 1'b1, 5'd7, 32'h1c00_0040};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [146:0] p);
        ds_to_es_data  = p;
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_data = '0;
        ms_ex_valid = 1'b0; wb_ex = 1'b0; wb_ertn_flush = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin: got %b want 1", es_allowin); end
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", es_to_ms_valid); end
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL rst_sram_en: got %b want 0", data_sram_en); end
        checks++; if (es_fwd_blk_data[38:37] !== 2'b00) begin errors++; $display("FAIL rst_fwd_blk: got %b want 00", es_fwd_blk_data[38:37]); end
    endtask

    task automatic test_alu();
        alu_vec_t tv [17];
        tv = '{
            '{4'd0,  32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004},
            '{4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE},
            '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
            '{4'd5,  32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F},
            '{4'd6,  32'h0F0F_0F0F, 32'hF0F0_0000, 32'h0000_F0F0},
            '{4'd7,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00},
            '{4'd8,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010},
            '{4'd9,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
            '{4'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
            '{4'd11, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678},
            '{4'd12, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE},
            '{4'd13, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
            '{4'd14, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
            '{4'd13, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{4'd15, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000}
        };
        for (int i = 0; i < 17; i++) begin
            issue(pkt(tv[i].op, 1'b0, 2'b00, tv[i].a, tv[i].b, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0));
            checks++; if (es_to_ms_valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d]: got %b want 1", i, es_to_ms_valid); end
            checks++; if (res !== tv[i].e) begin errors++; $display("FAIL alu_op%0d[%0d]: got %h want %h", tv[i].op, i, res, tv[i].e); end
            if (i == 0) begin
                checks++;
                if (es_fwd_blk_data !== {1'b0, 1'b1, 5'd7, 32'd4}) begin
                    errors++; $display("FAIL fwd_add: got %h want %h", es_fwd_blk_data, {1'b0, 1'b1, 5'd7, 32'd4});
                end
            end
        end
        step();
    endtask

    task automatic test_mem();
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h1000, 32'h3, 32'hAB, 1'b1, 1'b0, 2'b00, 1'b0));
        checks++; if (data_sram_en !== 1'b1) begin errors++; $display("FAIL sb_en: got %b want 1", data_sram_en); end
        checks++; if (data_sram_we !== 4'b1000) begin errors++; $display("FAIL sb_we: got %b want 1000", data_sram_we); end
        checks++; if (data_sram_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab", data_sram_wdata); end
        checks++; if (data_sram_addr !== 32'h1003) begin errors++; $display("FAIL sb_addr: got %h want 1003", data_sram_addr); end
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h1000, 32'h1, 32'hCDEF, 1'b1, 1'b0, 2'b01, 1'b0));
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL sh_ale_en: got %b want 0", data_sram_en); end
        checks++; if (ale !== 1'b1) begin errors++; $display("FAIL sh_ale: got %b want 1", ale); end
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h1000, 32'h2, 32'h1234_CDEF, 1'b1, 1'b0, 2'b01, 1'b0));
        checks++; if ({data_sram_en, data_sram_we, data_sram_wdata} !== {1'b1, 4'b1100, 32'hCDEF_CDEF}) begin
            errors++; $display("FAIL sh_lanes: got %b %b %h want 1 1100 cdefcdef", data_sram_en, data_sram_we, data_sram_wdata); end
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h1FF0, 32'h10, 32'h1234_5678, 1'b1, 1'b0, 2'b10, 1'b0));
        checks++; if ({data_sram_en, data_sram_we, data_sram_wdata} !== {1'b1, 4'b1111, 32'h1234_5678}) begin
            errors++; $display("FAIL sw_lanes: got %b %b %h want 1 1111 12345678", data_sram_en, data_sram_we, data_sram_wdata); end
        checks++; if (res !== 32'h2000) begin errors++; $display("FAIL sw_result_addr: got %h want 2000", res); end
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h2000, 32'h2, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0));
        checks++; if ({data_sram_en, ale} !== 2'b01) begin errors++; $display("FAIL lw_ale: got en/ale %b want 01", {data_sram_en, ale}); end
        ms_ex_valid = 1'b1;
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h2000, 32'h3, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0));
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL lb_msex_en: got %b want 0", data_sram_en); end
        ms_ex_valid = 1'b0;
        #1;
        checks++; if ({data_sram_en, data_sram_we} !== 5'b1_0000) begin errors++; $display("FAIL lb_en_we: got %b want 10000", {data_sram_en, data_sram_we}); end
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h1000, 32'h0, 32'hAB, 1'b1, 1'b0, 2'b00, 1'b1));
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL exin_en: got %b want 0", data_sram_en); end
        step();
    endtask

    task automatic test_load_stall();
        ms_allowin = 1'b0;
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h3000, 32'h4, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0));
        for (int c = 0; c < 3; c++) begin
            checks++; if ({data_sram_en, blk, es_allowin} !== 3'b010) begin
                errors++; $display("FAIL ld_stall[%0d]: got en/blk/allowin %b want 010", c, {data_sram_en, blk, es_allowin}); end
            if (c < 2) begin step(); #1; end
        end
        ms_allowin = 1'b1;
        #1;
        checks++; if ({data_sram_en, data_sram_we, data_sram_addr} !== {1'b1, 4'b0000, 32'h3004}) begin
            errors++; $display("FAIL ld_go: got %b %b %h want 1 0000 3004", data_sram_en, data_sram_we, data_sram_addr); end
        step(); #1;
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL ld_drain: got %b want 0", es_to_ms_valid); end
    endtask

    task automatic test_back_to_back();
        ds_to_es_valid = 1'b1;
        ds_to_es_data  = pkt(4'd0, 1'b0, 2'b00, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        step();
        ds_to_es_data  = pkt(4'd1, 1'b0, 2'b00, 32'd30, 32'd10, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        #1;
        checks++; if ({es_to_ms_valid, res} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_0: got %b %h want 1 3", es_to_ms_valid, res); end
        step();
        ds_to_es_data  = pkt(4'd7, 1'b0, 2'b00, 32'hFF, 32'h0F, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        #1;
        checks++; if ({es_to_ms_valid, res} !== {1'b1, 32'd20}) begin errors++; $display("FAIL b2b_1: got %b %h want 1 14", es_to_ms_valid, res); end
        step();
        ds_to_es_valid = 1'b0;
        #1;
        checks++; if ({es_to_ms_valid, res} !== {1'b1, 32'hF0}) begin errors++; $display("FAIL b2b_2: got %b %h want 1 f0", es_to_ms_valid, res); end
        step();
    endtask

    task automatic test_flush_alu();
        issue(pkt(4'd0, 1'b0, 2'b00, 32'h1000, 32'h0, 32'h55, 1'b1, 1'b0, 2'b10, 1'b0));
        wb_ertn_flush = 1'b1;
        #1;
        checks++; if ({es_to_ms_valid, data_sram_en} !== 2'b00) begin
            errors++; $display("FAIL flush_alu: got valid/en %b want 00", {es_to_ms_valid, data_sram_en}); end
        step();
        wb_ertn_flush = 1'b0;
        #1;
        checks++; if ({es_to_ms_valid, es_allowin} !== 2'b01) begin
            errors++; $display("FAIL flush_alu_after: got valid/allowin %b want 01", {es_to_ms_valid, es_allowin}); end
    endtask

`ifdef EXE_DIV_EN
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit hold);
        logic bad = 1'b0;
        issue(pkt(4'd0, 1'b1, op, a, b, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0));
        for (int i = 1; i <= 33; i++) begin
            if (es_to_ms_valid !== 1'b0 || blk !== 1'b1) bad = 1'b1;
            step(); #1;
        end
        checks++; if (bad) begin errors++; $display("FAIL div_wait op%0d %h/%h: early valid or blk low", op, a, b); end
        if (hold) begin
            ms_allowin = 1'b0;
            for (int h = 0; h < 2; h++) begin
                #1;
                checks++; if ({es_to_ms_valid, blk, es_allowin, res} !== {3'b100, exp}) begin
                    errors++; $display("FAIL div_hold[%0d]: got %b%b%b %h want 100 %h", h, es_to_ms_valid, blk, es_allowin, res, exp); end
                step();
            end
            ms_allowin = 1'b1;
            #1;
        end
        checks++; if ({es_to_ms_valid, res} !== {1'b1, exp}) begin
            errors++; $display("FAIL div op%0d %h/%h: got %b %h want 1 %h", op, a, b, es_to_ms_valid, res, exp); end
        step(); #1;
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL div_leave: got %b want 0", es_to_ms_valid); end
    endtask

    task automatic test_div();
        run_div(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
        run_div(2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_div(2'b10, 32'd7, 32'd0, 32'd0, 1'b0);
        run_div(2'b11, 32'd7, 32'd0, 32'd7, 1'b0);
        run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div(2'b10, 32'd100, 32'd7, 32'd14, 1'b0);
        run_div(2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
        run_div(2'b01, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0);
    endtask

    task automatic test_div_back_to_back();
        logic bad = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_data  = pkt(4'd0, 1'b1, 2'b10, 32'd50, 32'd5, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        step();
        ds_to_es_data  = pkt(4'd0, 1'b1, 2'b11, 32'd50, 32'd8, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        #1;
        for (int i = 1; i <= 33; i++) begin
            if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b0) bad = 1'b1;
            step(); #1;
        end
        checks++; if (bad) begin errors++; $display("FAIL b2b_div_wait: early valid or allowin"); end
        checks++; if ({es_to_ms_valid, es_allowin, res} !== {2'b11, 32'd10}) begin
            errors++; $display("FAIL b2b_div_a: got %b%b %h want 11 a", es_to_ms_valid, es_allowin, res); end
        step();
        ds_to_es_valid = 1'b0;
        #1;
        bad = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            if (es_to_ms_valid !== 1'b0) bad = 1'b1;
            step(); #1;
        end
        checks++; if (bad) begin errors++; $display("FAIL b2b_div_wait2: early valid"); end
        checks++; if ({es_to_ms_valid, res} !== {1'b1, 32'd2}) begin
            errors++; $display("FAIL b2b_div_b: got %b %h want 1 2", es_to_ms_valid, res); end
        step();
    endtask

    task automatic test_div_flush();
        issue(pkt(4'd0, 1'b1, 2'b00, 32'd99, 32'd3, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0));
        for (int i = 0; i < 10; i++) step();
        wb_ex = 1'b1;
        #1;
        checks++; if ({es_to_ms_valid, data_sram_en} !== 2'b00) begin
            errors++; $display("FAIL div_flush: got valid/en %b want 00", {es_to_ms_valid, data_sram_en}); end
        step();
        wb_ex = 1'b0;
        #1;
        checks++; if ({es_to_ms_valid, es_allowin, blk} !== 3'b010) begin
            errors++; $display("FAIL div_flush_after: got %b want 010", {es_to_ms_valid, es_allowin, blk}); end
        run_div(2'b00, 32'd99, 32'd3, 32'd33, 1'b0);
    endtask

    task automatic test_div_reset();
        issue(pkt(4'd0, 1'b1, 2'b00, 32'd12, 32'd4, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0));
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if ({es_to_ms_valid, es_allowin, blk} !== 3'b010) begin
            errors++; $display("FAIL div_reset: got %b want 010", {es_to_ms_valid, es_allowin, blk}); end
        run_div(2'b01, 32'd13, 32'd4, 32'd1, 1'b0);
    endtask
`else
    task automatic test_div_disabled();
        issue(pkt(4'd0, 1'b1, 2'b00, 32'd7, 32'd2, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0));
        checks++; if ({es_to_ms_valid, blk, res} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL div_disabled: got %b%b %h want 10 0", es_to_ms_valid, blk, res); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_load_stall();
        test_back_to_back();
        test_flush_alu();
`ifdef EXE_DIV_EN
        test_div();
        test_div_back_to_back();
        test_div_flush();
        test_div_reset();
`else
        test_div_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
